// File: rtl/iir_coeff_ctrl.sv
// Purpose : double-buffered IIR coefficient bank with drain/swap/flush sequencing around the sample path.
// Latency : accepted samples reach f_din/f_vin one cycle later; commit -> new bank after drain + 1 swap cycle.
// Backpressure: s_ready is registered and drops the cycle after an accepted commit until the flush finishes.
//
// Ports:
//   clk, rst                  sole clock, asynchronous active-high reset
//   cfg_we/addr/data          shadow coefficient write (addr 0..5 = B0,B1,B2,B3,A1,A2; 6,7 invalid)
//   cfg_commit                request to move the shadow bank into the active bank
//   cfg_busy, cfg_err         sequencer not in RUN / sticky configuration error
//   s_din, s_vin, s_ready     upstream sample handshake
//   f_din, f_vin, f_vout      sample stream to the filter and its output-valid strobe
//   b0..b3, a1, a2            active coefficient bank
//   out_mask                  filter outputs currently belong to injected flush zeros
module iir_coeff_ctrl #(
    parameter int DW        = 14,
    parameter int FLUSH_LEN = 4,
    parameter int DRAIN_TO  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    output logic          cfg_err,
    input  logic [DW-1:0] s_din,
    input  logic          s_vin,
    output logic          s_ready,
    output logic [DW-1:0] f_din,
    output logic          f_vin,
    input  logic          f_vout,
    output logic [DW-1:0] b0,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] b3,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic          out_mask
);

    localparam int NCOEF = 6;
    localparam int CW    = 5;
    localparam logic [CW-1:0] CNT_MAX = '1;

    // Drain timer counts 0..DRAIN_TO-1; the last value forces the swap.
    localparam int DCW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_TO > 0) ? DRAIN_TO - 1 : 0);

    // Flush index counts 0..FLUSH_LEN-1 while zeros are being injected.
    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NCOEF-1:0][DW-1:0] shadow_q;
    logic [NCOEF-1:0][DW-1:0] active_q;

    logic [CW-1:0]  out_cnt;
    logic [CW-1:0]  out_cnt_nxt;
    logic [CW-1:0]  flush_cnt;
    logic [CW-1:0]  flush_cnt_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [FCW-1:0] flush_idx;

    logic          addr_ok;
    logic          wr_ok;
    logic          wr_bad;
    logic          in_run;
    logic          commit_ok;
    logic          commit_bad;
    logic          accept;
    logic          drain_done;
    logic          flush_done;
    logic          flush_inj;
    logic          flush_dec;
    logic          err_nxt;

    logic          s_ready_nxt;
    logic          busy_nxt;
    logic          f_vin_nxt;
    logic [DW-1:0] f_din_nxt;
    logic          load_active;

    assign addr_ok    = (cfg_addr <= 3'd5);
    assign wr_ok      = cfg_we & addr_ok;
    assign wr_bad     = cfg_we & ~addr_ok;
    assign in_run     = (state == ST_RUN);
    assign commit_ok  = cfg_commit & in_run;
    assign commit_bad = cfg_commit & ~in_run;
    // s_ready is only ever high in RUN, but the state term keeps intent explicit.
    assign accept     = s_vin & s_ready & in_run;

    assign drain_done = (out_cnt == '0) || (drain_cnt == DRAIN_LAST);
    assign flush_done = (flush_idx == FLUSH_LAST);

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (commit_ok) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_nxt = (FLUSH_LEN > 0) ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (flush_done) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: outputs. Handshake/stream outputs are registered, so they
    // are derived from the state being entered rather than the current one.
    // ------------------------------------------------------------------
    always_comb begin
        s_ready_nxt = 1'b0;
        busy_nxt    = 1'b1;
        f_vin_nxt   = 1'b0;
        f_din_nxt   = f_din;
        load_active = (state == ST_SWAP);
        if (state_nxt == ST_RUN) begin
            s_ready_nxt = 1'b1;
            busy_nxt    = 1'b0;
        end
        if (accept) begin
            f_vin_nxt = 1'b1;
            f_din_nxt = s_din;
        end
        if (state_nxt == ST_FLUSH) begin
            f_vin_nxt = 1'b1;
            f_din_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready  <= 1'b0;
            cfg_busy <= 1'b0;
            f_vin    <= 1'b0;
            f_din    <= '0;
        end else begin
            s_ready  <= s_ready_nxt;
            cfg_busy <= busy_nxt;
            f_vin    <= f_vin_nxt;
            f_din    <= f_din_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error: a fault in the same cycle as an accepted commit wins.
    // ------------------------------------------------------------------
    always_comb begin
        err_nxt = cfg_err;
        if (wr_bad || commit_bad) begin
            err_nxt = 1'b1;
        end else if (commit_ok) begin
            err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Coefficient banks. The active copy samples the shadow register value
    // before any write landing in the same SWAP cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (load_active) begin
                active_q <= shadow_q;
            end
            if (wr_ok) begin
                shadow_q[cfg_addr] <= cfg_data;
            end
        end
    end

    assign b0 = active_q[0];
    assign b1 = active_q[1];
    assign b2 = active_q[2];
    assign b3 = active_q[3];
    assign a1 = active_q[4];
    assign a2 = active_q[5];

    // ------------------------------------------------------------------
    // Outstanding-sample tracker (saturating both ways). Cleared in SWAP so
    // a forced swap does not leave stale credit against the new bank.
    // ------------------------------------------------------------------
    always_comb begin
        out_cnt_nxt = out_cnt;
        if (state == ST_SWAP) begin
            out_cnt_nxt = '0;
        end else if (f_vin && !f_vout && (out_cnt != CNT_MAX)) begin
            out_cnt_nxt = out_cnt + CW'(1);
        end else if (!f_vin && f_vout && (out_cnt != '0)) begin
            out_cnt_nxt = out_cnt - CW'(1);
        end
    end

    // Flush tracker: counts injected zeros still inside the filter.
    assign flush_inj = f_vin & (state == ST_FLUSH);
    assign flush_dec = f_vout & (flush_cnt != '0);

    always_comb begin
        flush_cnt_nxt = flush_cnt;
        if (flush_inj && !flush_dec && (flush_cnt != CNT_MAX)) begin
            flush_cnt_nxt = flush_cnt + CW'(1);
        end else if (!flush_inj && flush_dec) begin
            flush_cnt_nxt = flush_cnt - CW'(1);
        end
    end

    assign out_mask = (flush_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt   <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
            flush_idx <= '0;
        end else begin
            out_cnt   <= out_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            drain_cnt <= (state == ST_DRAIN && drain_cnt != DRAIN_LAST) ? drain_cnt + DCW'(1) : '0;
            flush_idx <= (state == ST_FLUSH && flush_idx != FLUSH_LAST) ? flush_idx + FCW'(1) : '0;
        end
    end

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Purpose : directed + randomized checking of iir_coeff_ctrl against a cycle-level behavioural model.
// Latency : model predicts every registered output one edge after the inputs it consumed.
// Backpressure: the bench only offers/holds samples; acceptance is judged from the model's ready.
module tb_iir_coeff_ctrl;

    localparam int DW        = 14;
    localparam int FLUSH_LEN = 4;
    localparam int DRAIN_TO  = 16;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_SWAP  = 2;
    localparam int M_FLUSH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic          cfg_commit = 1'b0;
    logic          cfg_busy;
    logic          cfg_err;
    logic [DW-1:0] s_din = '0;
    logic          s_vin = 1'b0;
    logic          s_ready;
    logic [DW-1:0] f_din;
    logic          f_vin;
    logic          f_vout = 1'b0;
    logic [DW-1:0] b0, b1, b2, b3, a1, a2;
    logic          out_mask;

    iir_coeff_ctrl #(.DW(DW), .FLUSH_LEN(FLUSH_LEN), .DRAIN_TO(DRAIN_TO)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .s_din(s_din), .s_vin(s_vin), .s_ready(s_ready),
        .f_din(f_din), .f_vin(f_vin), .f_vout(f_vout),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .a1(a1), .a2(a2),
        .out_mask(out_mask)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: mode, banks, counters and the registered outputs.
    int m_mode, m_out, m_fl, m_dspent, m_fspent;
    int m_err, m_rdy, m_busy, m_fvin, m_fdin;
    int m_sh[6];
    int m_act[6];

    // Filter emulation: 0 = f_vout tied low, 1 = echo f_vin 2 cycles later, 2 = echo plus random extras.
    int vout_mode = 1;
    bit d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;

    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RUN; m_out = 0; m_fl = 0; m_dspent = 0; m_fspent = 0;
        m_err = 0; m_rdy = 0; m_busy = 0; m_fvin = 0; m_fdin = 0;
        for (int i = 0; i < 6; i++) begin
            m_sh[i] = 0;
            m_act[i] = 0;
        end
    endtask

    // One clock of the sequencer, written from the behavioural rules.
    task automatic model_next();
        int nxt;
        bit acc;
        bit inj;
        bit dec;
        acc = s_vin && (m_rdy != 0) && (m_mode == M_RUN);

        nxt = m_mode;
        case (m_mode)
            M_RUN:   if (cfg_commit) begin nxt = M_DRAIN; m_dspent = 0; end
            M_DRAIN: begin
                m_dspent++;
                if (m_out == 0 || m_dspent == DRAIN_TO) nxt = M_SWAP;
            end
            M_SWAP:  begin nxt = (FLUSH_LEN > 0) ? M_FLUSH : M_RUN; m_fspent = 0; end
            default: begin
                m_fspent++;
                if (m_fspent == FLUSH_LEN) nxt = M_RUN;
            end
        endcase

        if ((cfg_we && cfg_addr > 5) || (cfg_commit && m_mode != M_RUN)) m_err = 1;
        else if (cfg_commit) m_err = 0;

        if (m_mode == M_SWAP) m_act = m_sh;
        if (cfg_we && cfg_addr <= 5) m_sh[cfg_addr] = int'(cfg_data);

        if (m_mode == M_SWAP) m_out = 0;
        else if (m_fvin != 0 && !f_vout) m_out = (m_out < 31) ? m_out + 1 : 31;
        else if (m_fvin == 0 && f_vout && m_out > 0) m_out = m_out - 1;

        inj = (m_fvin != 0) && (m_mode == M_FLUSH);
        dec = f_vout && (m_fl > 0);
        if (inj && !dec) m_fl = (m_fl < 31) ? m_fl + 1 : 31;
        else if (dec && !inj) m_fl = m_fl - 1;

        m_fdin = (nxt == M_FLUSH) ? 0 : (acc ? int'(s_din) : m_fdin);
        m_fvin = (acc || nxt == M_FLUSH) ? 1 : 0;
        m_rdy  = (nxt == M_RUN) ? 1 : 0;
        m_busy = (nxt != M_RUN) ? 1 : 0;
        m_mode = nxt;
    endtask

    task automatic check_all();
        logic [127:0] eb;
        logic [127:0] ob;
        eb = '0;
        ob = '0;
        for (int i = 0; i < 6; i++) eb[i*DW +: DW] = m_act[i][DW-1:0];
        ob[0*DW +: DW] = b0; ob[1*DW +: DW] = b1; ob[2*DW +: DW] = b2;
        ob[3*DW +: DW] = b3; ob[4*DW +: DW] = a1; ob[5*DW +: DW] = a2;
        chk("f_vin",    128'(f_vin),    128'(m_fvin));
        chk("f_din",    128'(f_din),    128'(m_fdin));
        chk("s_ready",  128'(s_ready),  128'(m_rdy));
        chk("cfg_busy", 128'(cfg_busy), 128'(m_busy));
        chk("cfg_err",  128'(cfg_err),  128'(m_err));
        chk("out_mask", 128'(out_mask), 128'(m_fl != 0));
        chk("bank",     ob,             eb);
    endtask

    task automatic chk_bank(input string tag, input int base, input int step);
        logic [DW-1:0] ob[6];
        ob[0] = b0; ob[1] = b1; ob[2] = b2; ob[3] = b3; ob[4] = a1; ob[5] = a2;
        for (int i = 0; i < 6; i++) chk(tag, 128'(ob[i]), 128'(base + i * step));
    endtask

    // Apply the current inputs for one cycle, advance the model, check after the edge.
    task automatic cycle();
        case (vout_mode)
            0:       f_vout = 1'b0;
            1:       f_vout = d3;
            default: f_vout = d3 | ($urandom_range(0, 5) == 0);
        endcase
        if (rst) model_reset();
        else begin
            if (s_vin && m_rdy != 0 && m_mode == M_RUN) sent.push_back(s_din);
            model_next();
        end
        @(posedge clk);
        #1;
        d3 = d2; d2 = d1; d1 = f_vin;
        if (f_vin && f_din != '0) got.push_back(f_din);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_data = DW'(data);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic commit_cyc();
        cfg_commit = 1'b1;
        cycle();
        cfg_commit = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (cfg_busy && n < limit) begin
            cycle();
            n++;
        end
        chk(tag, 128'(cfg_busy), 128'(0));
    endtask

    initial begin
        int nz, nm, nb, guard, cur;
        bit found, acc;

        // ---- reset ----
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_all();
        chk("rst_s_ready", 128'(s_ready), 128'(0));
        run(2);
        rst = 1'b0;
        chk("rdy_before_edge", 128'(s_ready), 128'(0));
        cycle();
        chk("rdy_after_release", 128'(s_ready), 128'(1));

        // ---- basic swap with echoing filter ----
        vout_mode = 1;
        for (int i = 0; i < 6; i++) wr(i, i + 1);
        chk_bank("bank_unchanged_by_write", 0, 0);
        commit_cyc();
        nz = 0; nm = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (f_vin && f_din == '0) nz++;
            if (out_mask) nm++;
        end
        chk("flush_zero_count", 128'(nz), 128'(FLUSH_LEN));
        chk("out_mask_cycles", 128'(nm), 128'(5));
        chk_bank("bank_after_swap", 1, 1);

        // ---- continuous stream across a commit ----
        sent.delete(); got.delete();
        s_vin = 1'b1;
        cur = 100;
        for (int k = 0; k < 40; k++) begin
            s_din = DW'(cur);
            cfg_commit = (k == 10);
            acc = (m_rdy != 0) && (m_mode == M_RUN);
            cycle();
            cfg_commit = 1'b0;
            if (acc) cur++;
            if (k == 10) begin
                chk("commit_fwd_vld", 128'(f_vin), 128'(1));
                chk("commit_fwd_dat", 128'(f_din), 128'(110));
                chk("rdy_after_commit", 128'(s_ready), 128'(0));
            end
        end
        s_vin = 1'b0;
        run(6);
        chk("sb_count", 128'(got.size()), 128'(sent.size()));
        for (int i = 0; i < sent.size() && i < got.size(); i++) chk("sb_data", 128'(got[i]), 128'(sent[i]));

        // ---- drain timeout with silent filter ----
        vout_mode = 0;
        run(4);
        s_vin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_din = DW'(500 + k);
            cycle();
        end
        s_vin = 1'b0;
        run(2);
        commit_cyc();
        nb = 0; guard = 0;
        while (cfg_busy && !f_vin && guard < 60) begin
            nb++;
            cycle();
            guard++;
        end
        chk("drain_timeout_len", 128'(nb), 128'(DRAIN_TO + 1));
        vout_mode = 1;
        wait_idle("idle_after_timeout", 20);
        run(4);
        // Outstanding count was cleared at the swap, so this drain is immediate.
        commit_cyc();
        nb = 0; guard = 0;
        while (cfg_busy && !f_vin && guard < 60) begin
            nb++;
            cycle();
            guard++;
        end
        chk("drain_after_clear_len", 128'(nb), 128'(2));
        wait_idle("idle_after_clear", 20);
        run(3);

        // ---- sticky error ----
        wr(7, 'h3AB);
        chk("err_bad_addr", 128'(cfg_err), 128'(1));
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = DW'('h155);
        commit_cyc();
        cfg_we = 1'b0;
        chk("err_bad_wr_with_commit", 128'(cfg_err), 128'(1));
        commit_cyc();
        chk("err_commit_in_drain", 128'(cfg_err), 128'(1));
        wait_idle("idle_err", 20);
        run(3);
        chk_bank("bank_after_bad_writes", 1, 1);
        commit_cyc();
        chk("err_cleared", 128'(cfg_err), 128'(0));
        wait_idle("idle_err_clear", 20);
        run(3);

        // ---- shadow write in the SWAP cycle ----
        commit_cyc();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_mode == M_SWAP) begin
                found = 1'b1;
                cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = DW'('h1FFF);
            end
            cycle();
            cfg_we = 1'b0;
        end
        chk("swap_reached", 128'(found), 128'(1));
        wait_idle("idle_swapwr", 20);
        chk("b2_old_value", 128'(b2), 128'(3));
        run(3);
        commit_cyc();
        wait_idle("idle_swapwr2", 20);
        chk("b2_new_value", 128'(b2), 128'('h1FFF));

        // ---- asynchronous reset during FLUSH ----
        run(3);
        commit_cyc();
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_mode == M_FLUSH) found = 1'b1;
            else cycle();
        end
        chk("flush_reached", 128'(found), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_f_vin", 128'(f_vin), 128'(0));
        chk("arst_f_din", 128'(f_din), 128'(0));
        chk("arst_s_ready", 128'(s_ready), 128'(0));
        chk("arst_busy", 128'(cfg_busy), 128'(0));
        chk("arst_err", 128'(cfg_err), 128'(0));
        chk("arst_mask", 128'(out_mask), 128'(0));
        chk_bank("arst_bank", 0, 0);
        model_reset();
        run(2);
        rst = 1'b0;
        chk("arst_rdy_held", 128'(s_ready), 128'(0));
        cycle();
        chk("arst_rdy_rise", 128'(s_ready), 128'(1));

        // ---- randomized traffic ----
        vout_mode = 2;
        for (int k = 0; k < 600; k++) begin
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_addr   = 3'($urandom_range(0, 7));
            cfg_data   = DW'($urandom);
            cfg_commit = ($urandom_range(0, 24) == 0);
            s_vin      = 1'($urandom_range(0, 1));
            s_din      = DW'($urandom);
            cycle();
        end
        cfg_we = 1'b0; cfg_commit = 1'b0; s_vin = 1'b0;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
